// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: in-order req/gnt fetch into a DEPTH-entry prefetch FIFO with a valid/ready head.
// Latency: fetched word is visible one cycle after rvalid; redirect shows the new address next cycle.
// Backpressure: instr_ready low fills the FIFO, and credits (outstanding + buffered < DEPTH) then stall imem_req.
module instr_fetch_unit #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready
);
    localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int          CW      = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   ret_pc_q, ret_pc_d;
    logic [CW-1:0] out_cnt_q, out_cnt_d;
    logic [CW-1:0] drop_cnt_q, drop_cnt_d;
    logic [CW-1:0] fifo_cnt_q, fifo_cnt_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [31:0]   head_instr_q, head_instr_d;
    logic [31:0]   head_pc_q, head_pc_d;
    logic [31:0]   mem_instr_q [DEPTH];
    logic [31:0]   mem_pc_q    [DEPTH];

    logic [CW:0]   credit_used;
    logic          issue;
    logic          rsp_drop;
    logic          rsp_take;
    logic          rsp_any;
    logic          push;
    logic          pop;
    logic [31:0]   redirect_pc_al;
    logic          unused_rpc_lsbs;

    // Word-alignment drops the low address bits of the redirect target.
    assign redirect_pc_al  = {redirect_pc[31:2], 2'b00};
    assign unused_rpc_lsbs = ^redirect_pc[1:0];

    // Credits count everything issued-but-live plus everything buffered, so a push always finds room.
    assign credit_used = {1'b0, out_cnt_q} + {1'b0, fifo_cnt_q};
    assign imem_req    = !reset && (credit_used < DEPTH_W);
    assign imem_addr   = fetch_pc_q;
    assign issue       = imem_req && imem_gnt;

    // Stale responses are always older than live ones, so they are drained first; rvalid with nothing due is ignored.
    assign rsp_drop = imem_rvalid && (drop_cnt_q != '0);
    assign rsp_take = imem_rvalid && (drop_cnt_q == '0) && (out_cnt_q != '0);
    assign rsp_any  = rsp_drop || rsp_take;
    assign push     = rsp_take && !redirect;
    assign pop      = instr_valid && instr_ready;

    assign instr_valid = (fifo_cnt_q != '0);
    assign instr       = head_instr_q;
    assign instr_pc    = head_pc_q;

    // Next-state for fetch/return PCs, credit counters, FIFO pointers and the registered head.
    always_comb begin
        fetch_pc_d   = fetch_pc_q;
        ret_pc_d     = ret_pc_q;
        out_cnt_d    = out_cnt_q;
        drop_cnt_d   = drop_cnt_q;
        fifo_cnt_d   = fifo_cnt_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        head_instr_d = head_instr_q;
        head_pc_d    = head_pc_q;
        if (redirect) begin
            // Everything still due from memory, including a grant in this very cycle, becomes stale.
            fetch_pc_d = redirect_pc_al;
            ret_pc_d   = redirect_pc_al;
            drop_cnt_d = drop_cnt_q + out_cnt_q + CW'(issue) - CW'(rsp_any);
            out_cnt_d  = '0;
            fifo_cnt_d = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
        end else begin
            if (issue) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            out_cnt_d = out_cnt_q + CW'(issue) - CW'(rsp_take);
            if (rsp_drop) begin
                drop_cnt_d = drop_cnt_q - CW'(1);
            end
            if (push) begin
                ret_pc_d = ret_pc_q + 32'd4;
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            fifo_cnt_d = fifo_cnt_q + CW'(push) - CW'(pop);
            // Head holds its last value when empty; a push into an empty slot lands on the head directly.
            if (fifo_cnt_d != '0) begin
                if (push && (wr_ptr_q == rd_ptr_d)) begin
                    head_instr_d = imem_rdata;
                    head_pc_d    = ret_pc_q;
                end else begin
                    head_instr_d = mem_instr_q[rd_ptr_d];
                    head_pc_d    = mem_pc_q[rd_ptr_d];
                end
            end
        end
    end

    // Control state registers with synchronous reset; in-flight responses are forgotten on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q   <= RESET_PC;
            ret_pc_q     <= RESET_PC;
            out_cnt_q    <= '0;
            drop_cnt_q   <= '0;
            fifo_cnt_q   <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            head_instr_q <= '0;
            head_pc_q    <= '0;
        end else begin
            fetch_pc_q   <= fetch_pc_d;
            ret_pc_q     <= ret_pc_d;
            out_cnt_q    <= out_cnt_d;
            drop_cnt_q   <= drop_cnt_d;
            fifo_cnt_q   <= fifo_cnt_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            head_instr_q <= head_instr_d;
            head_pc_q    <= head_pc_d;
        end
    end

    // FIFO payload storage; contents are qualified by the count, so it needs no reset.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            mem_instr_q[wr_ptr_q] <= imem_rdata;
            mem_pc_q[wr_ptr_q]    <= ret_pc_q;
        end
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed vector table, hand-written corner sequences, and randomized traffic
// checked against a stream-level reference model (epochs, expected PC sequence, credit occupancy).
module tb_instr_fetch_unit;
    localparam int DEPTH = 4;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;

    logic [31:0] addr2;
    logic        unused_req2;
    logic        unused_vld2;
    logic [31:0] unused_instr2;
    logic [31:0] unused_pc2;

    instr_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready)
    );

    instr_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) dut2 (
        .clk(clk), .reset(reset),
        .imem_req(unused_req2), .imem_addr(addr2), .imem_gnt(1'b1),
        .imem_rvalid(1'b0), .imem_rdata(32'h0),
        .redirect(1'b0), .redirect_pc(32'h0),
        .instr_valid(unused_vld2), .instr(unused_instr2), .instr_pc(unused_pc2), .instr_ready(1'b1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b expected=%b", nm, act, exp);
        end
    endtask

    // Memory contents: a fixed scramble of the address so data never equals its PC.
    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    // ---------------- memory + reference model state ----------------
    typedef struct {
        logic [31:0] addr;
        int          ep;
        int          due;
    } mq_t;
    mq_t mq[$];

    int          cyc = 0;
    int          epoch = 0;
    int          live_iss = 0;
    int          live_ret = 0;
    int          popped = 0;
    logic [31:0] exp_fetch = 32'h0;
    logic [31:0] exp_pop = 32'h0;

    int          gnt_mode = 0;
    int          rdy_mode = 0;
    int          lat_min = 1;
    int          lat_max = 1;
    bit          redir_now = 1'b0;
    logic [31:0] redir_pc = 32'h0;
    bit          spur_en = 1'b0;

    int          n_issue = 0;
    int          stale_rx = 0;
    bit          seen_vld = 1'b0;
    int          first_vld_cyc = 0;
    logic [31:0] first_vld_pc = 32'h0;

    // One clock cycle: drive memory/consumer, check outputs against the model, advance the model.
    task automatic step();
        mq_t h;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = memf(mq[0].addr);
        end else if (spur_en && mq.size() == 0 && $urandom_range(0, 7) == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = $urandom;
        end
        imem_gnt    = (gnt_mode == 2) ? 1'($urandom_range(0, 1)) : (gnt_mode == 1);
        instr_ready = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode == 1);
        redirect    = redir_now;
        redirect_pc = redir_pc;
        #1;
        chk1("m_req", imem_req, (live_iss - popped) < DEPTH);
        if (imem_req) chk("m_addr", imem_addr, exp_fetch);
        chk1("m_valid", instr_valid, (live_ret - popped) > 0);
        if (instr_valid && (live_ret > popped)) begin
            chk("m_pc", instr_pc, exp_pop);
            chk("m_instr", instr, memf(exp_pop));
        end
        if (instr_valid && !seen_vld) begin
            seen_vld      = 1'b1;
            first_vld_cyc = cyc;
            first_vld_pc  = instr_pc;
        end
        if (instr_valid && instr_ready && (live_ret > popped)) begin
            popped++;
            exp_pop += 32'd4;
        end
        if (imem_rvalid && mq.size() > 0) begin
            h = mq.pop_front();
            if (h.ep == epoch) live_ret++;
            else stale_rx++;
        end
        if (imem_req && imem_gnt) begin
            n_issue++;
            mq.push_back('{addr: imem_addr, ep: epoch, due: cyc + $urandom_range(lat_min, lat_max)});
            if (!redirect) begin
                live_iss++;
                exp_fetch += 32'd4;
            end
        end
        if (redirect) begin
            epoch++;
            live_iss  = 0;
            live_ret  = 0;
            popped    = 0;
            exp_fetch = {redir_pc[31:2], 2'b00};
            exp_pop   = {redir_pc[31:2], 2'b00};
        end
        @(negedge clk);
        cyc++;
    endtask

    // Apply reset for one edge, check the reset state, then release it with a fresh model.
    task automatic do_reset();
        reset       = 1'b1;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        instr_ready = 1'b0;
        redirect    = 1'b0;
        @(negedge clk);
        cyc++;
        chk1("rst_req", imem_req, 1'b0);
        chk("rst_addr", imem_addr, 32'h0);
        chk1("rst_valid", instr_valid, 1'b0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_pc", instr_pc, 32'h0);
        chk("rst_addr2", addr2, 32'hFFFF_FFF8);
        mq.delete();
        live_iss  = 0;
        live_ret  = 0;
        popped    = 0;
        exp_fetch = 32'h0;
        exp_pop   = 32'h0;
        redir_now = 1'b0;
        reset     = 1'b0;
    endtask

    typedef struct {
        logic        gnt;
        logic        rv;
        logic [31:0] ra;
        logic        rdy;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_vld;
        logic [31:0] e_pc;
    } vec_t;

    initial begin
        vec_t        vt[7];
        logic [31:0] exp2[3];
        int          t;

        reset = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        redirect = 1'b0; redirect_pc = 32'h0; instr_ready = 1'b0;

        // Zero-wait streaming: one word per cycle, PCs 0,4,8,C.
        vt[0] = '{1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h00, 1'b0, 32'h0};
        vt[1] = '{1'b1, 1'b1, 32'h0, 1'b1, 1'b1, 32'h04, 1'b0, 32'h0};
        vt[2] = '{1'b1, 1'b1, 32'h4, 1'b1, 1'b1, 32'h08, 1'b1, 32'h0};
        vt[3] = '{1'b1, 1'b1, 32'h8, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h4};
        vt[4] = '{1'b0, 1'b1, 32'hC, 1'b1, 1'b1, 32'h10, 1'b1, 32'h8};
        vt[5] = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h10, 1'b1, 32'hC};
        vt[6] = '{1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h10, 1'b0, 32'h0};
        exp2[0] = 32'hFFFF_FFF8; exp2[1] = 32'hFFFF_FFFC; exp2[2] = 32'h0000_0000;

        do_reset();
        for (int i = 0; i < 7; i++) begin
            imem_gnt    = vt[i].gnt;
            imem_rvalid = vt[i].rv;
            imem_rdata  = vt[i].rv ? memf(vt[i].ra) : 32'h0;
            instr_ready = vt[i].rdy;
            #1;
            chk1($sformatf("t1_req[%0d]", i), imem_req, vt[i].e_req);
            chk($sformatf("t1_addr[%0d]", i), imem_addr, vt[i].e_addr);
            chk1($sformatf("t1_valid[%0d]", i), instr_valid, vt[i].e_vld);
            if (vt[i].e_vld) begin
                chk($sformatf("t1_pc[%0d]", i), instr_pc, vt[i].e_pc);
                chk($sformatf("t1_instr[%0d]", i), instr, memf(vt[i].e_pc));
            end
            if (i < 3) chk($sformatf("t5_wrap_addr[%0d]", i), addr2, exp2[i]);
            @(negedge clk);
            cyc++;
        end

        // Consumer stalled: exactly DEPTH issues, then req drops; releasing ready drains in order and resumes.
        do_reset();
        gnt_mode = 1; rdy_mode = 0; lat_min = 1; lat_max = 1; n_issue = 0;
        repeat (8) step();
        chk("t2_issues", n_issue, 4);
        chk1("t2_req_off", imem_req, 1'b0);
        chk1("t2_full_valid", instr_valid, 1'b1);
        chk("t2_head_pc", instr_pc, 32'h0);
        rdy_mode = 1;
        repeat (6) step();
        chk1("t2_resumed", n_issue > 4, 1'b1);

        // Redirect to 0x103 with two requests in flight.
        do_reset();
        gnt_mode = 1; rdy_mode = 1; lat_min = 3; lat_max = 3;
        step(); step();
        gnt_mode = 0; redir_now = 1'b1; redir_pc = 32'h0000_0103; stale_rx = 0;
        step();
        redir_now = 1'b0;
        chk("t3_new_addr", imem_addr, 32'h0000_0100);
        chk1("t3_flushed", instr_valid, 1'b0);
        gnt_mode = 1; lat_min = 1; lat_max = 1; seen_vld = 1'b0;
        repeat (10) step();
        chk("t3_stale", stale_rx, 2);
        chk1("t3_seen", seen_vld, 1'b1);
        chk("t3_first_pc", first_vld_pc, 32'h0000_0100);

        // Redirect coinciding with a grant and a pop; zero-wait latency to first new word.
        do_reset();
        gnt_mode = 1; rdy_mode = 1; lat_min = 1; lat_max = 1;
        repeat (5) step();
        chk1("t4_pre_valid", instr_valid, 1'b1);
        stale_rx = 0; redir_now = 1'b1; redir_pc = 32'h2000_0042; t = cyc;
        step();
        redir_now = 1'b0; seen_vld = 1'b0;
        chk1("t4_flushed", instr_valid, 1'b0);
        chk("t4_new_addr", imem_addr, 32'h2000_0040);
        repeat (6) step();
        chk("t4_stale", stale_rx, 1);
        chk("t4_first_cyc", first_vld_cyc, t + 3);
        chk("t4_first_pc", first_vld_pc, 32'h2000_0040);

        // Reset mid-burst with the FIFO half full, then a clean restart.
        do_reset();
        gnt_mode = 1; rdy_mode = 0; lat_min = 1; lat_max = 1;
        repeat (3) step();
        chk1("t6_pre_valid", instr_valid, 1'b1);
        do_reset();
        rdy_mode = 1; seen_vld = 1'b0;
        repeat (6) step();
        chk("t6_first_pc", first_vld_pc, 32'h0);

        // Randomized traffic: variable latency, random grants/ready, redirects, spurious rvalid, rare resets.
        do_reset();
        gnt_mode = 2; rdy_mode = 2; lat_min = 1; lat_max = 3; spur_en = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            redir_now = ($urandom_range(0, 15) == 0);
            redir_pc  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
            if ($urandom_range(0, 499) == 0) do_reset();
            else step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
